// File: rtl/word_assembler_pkg.sv
// rtl/word_assembler_pkg.sv - shared constants, state enum and char helper for the word assembler
package word_assembler_pkg;

  localparam int MAX_CHARS = 15;
  localparam int CHAR_W    = 8;
  localparam int WORD_W    = MAX_CHARS * CHAR_W;

  localparam logic [CHAR_W-1:0] CHAR_REST = 8'h00;
  localparam logic [CHAR_W-1:0] CHAR_BKSP = 8'h08;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_START   = 3'd2,
    S_WAIT    = 3'd3,
    S_DONE    = 3'd4
  } wa_state_e;

  function automatic logic is_letter(input logic [CHAR_W-1:0] c);
    return (c != CHAR_REST) && (c != CHAR_BKSP);
  endfunction

endpackage

// File: rtl/word_assembler_if.sv
// rtl/word_assembler_if.sv - classifier/matcher side signals of the word assembler
interface word_assembler_if;
  import word_assembler_pkg::*;

  logic              i_WA_char_valid;
  logic [CHAR_W-1:0] i_WA_char;
  logic              i_WA_commit;
  logic              i_WA_clear;
  logic              i_WA_dtw_finish;
  logic [WORD_W-1:0] i_WA_dtw_word;

  logic [WORD_W-1:0] o_WA_word;
  logic [3:0]        o_WA_len;
  logic              o_WA_start;
  logic [WORD_W-1:0] o_WA_result;
  logic              o_WA_result_valid;
  logic              o_WA_overflow;
  logic [2:0]        o_WA_state;

  modport master (
    output i_WA_char_valid, i_WA_char, i_WA_commit, i_WA_clear, i_WA_dtw_finish, i_WA_dtw_word,
    input  o_WA_word, o_WA_len, o_WA_start, o_WA_result, o_WA_result_valid, o_WA_overflow, o_WA_state
  );

  modport slave (
    input  i_WA_char_valid, i_WA_char, i_WA_commit, i_WA_clear, i_WA_dtw_finish, i_WA_dtw_word,
    output o_WA_word, o_WA_len, o_WA_start, o_WA_result, o_WA_result_valid, o_WA_overflow, o_WA_state
  );

endinterface

// File: rtl/word_assembler_char_debouncer.sv
// rtl/word_assembler_char_debouncer.sv - accepts a classifier char once it has been seen
// STABLE_CNT consecutive valid cycles; emits a single accept pulse per run.
module char_debouncer
  import word_assembler_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CHAR_W-1:0] char_i,
  output logic              accept_o,
  output logic [CHAR_W-1:0] char_o
);

  localparam logic [3:0] TARGET = 4'(STABLE_CNT);

  logic [CHAR_W-1:0] cand_q, cand_d;
  logic [3:0]        cnt_q, cnt_d;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    accept_o = 1'b0;
    if (flush_i) begin
      cand_d = '0;
      cnt_d  = '0;
    end else if (valid_i) begin
      if (char_i == cand_q) begin
        if (cnt_q != 4'hF) cnt_d = cnt_q + 4'd1;
      end else begin
        cand_d = char_i;
        cnt_d  = 4'd1;
      end
      // Fire only on the transition into TARGET, so saturation never re-fires.
      accept_o = (cnt_d == TARGET) && ((cnt_q != TARGET) || (char_i != cand_q));
    end
  end

  assign char_o = cand_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - builds a word from debounced gesture chars and hands it to the DTW matcher
module word_assembler
  import word_assembler_pkg::*;
#(
  parameter int STABLE_CNT = 4
) (
  input  logic           i_WA_clk,
  input  logic           i_WA_rst_n,
  word_assembler_if.slave bus
);

  wa_state_e         state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [3:0]        len_q, len_d;
  logic [CHAR_W-1:0] last_q, last_d;
  logic              ovf_q, ovf_d;
  logic [WORD_W-1:0] result_q, result_d;

  logic              flush;
  logic              acc;
  logic [CHAR_W-1:0] acc_char;
  logic [3:0]        bk_idx;

  // Debounce is frozen while the matcher owns the word, and wiped by clear.
  assign flush = (state_q == S_START) || (state_q == S_WAIT) ||
                 (((state_q == S_IDLE) || (state_q == S_COLLECT)) && bus.i_WA_clear);

  char_debouncer #(.STABLE_CNT(STABLE_CNT)) u_debouncer (
    .clk_i    (i_WA_clk),
    .rst_n_i  (i_WA_rst_n),
    .flush_i  (flush),
    .valid_i  (bus.i_WA_char_valid),
    .char_i   (bus.i_WA_char),
    .accept_o (acc),
    .char_o   (acc_char)
  );

  assign bk_idx = len_q - 4'd1;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    len_d    = len_q;
    last_d   = last_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE, S_COLLECT: begin
        if (bus.i_WA_clear) begin
          word_d  = '0;
          len_d   = '0;
          last_d  = CHAR_REST;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end else if (bus.i_WA_commit && (state_q == S_COLLECT)) begin
          state_d = S_START;
        end else if (acc) begin
          if (is_letter(acc_char)) begin
            if (acc_char != last_q) begin
              last_d = acc_char;
              if (len_q == 4'(MAX_CHARS)) begin
                ovf_d = 1'b1;
              end else begin
                word_d[{len_q, 3'b000} +: CHAR_W] = acc_char;
                len_d   = len_q + 4'd1;
                state_d = S_COLLECT;
              end
            end
          end else if (acc_char == CHAR_REST) begin
            last_d = CHAR_REST;
          end else if (len_q != 4'd0) begin
            word_d[{bk_idx, 3'b000} +: CHAR_W] = '0;
            len_d  = bk_idx;
            last_d = CHAR_REST;
            if (bk_idx == 4'd0) state_d = S_IDLE;
          end
        end
      end
      S_START: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.i_WA_dtw_finish) begin
          result_d = bus.i_WA_dtw_word;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        word_d  = '0;
        len_d   = '0;
        last_d  = CHAR_REST;
        ovf_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_WA_clk or negedge i_WA_rst_n) begin
    if (!i_WA_rst_n) begin
      state_q  <= S_IDLE;
      word_q   <= '0;
      len_q    <= '0;
      last_q   <= CHAR_REST;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      word_q   <= word_d;
      len_q    <= len_d;
      last_q   <= last_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

  assign bus.o_WA_word         = word_q;
  assign bus.o_WA_len          = len_q;
  assign bus.o_WA_start        = (state_q == S_START);
  assign bus.o_WA_result       = result_q;
  assign bus.o_WA_result_valid = (state_q == S_DONE);
  assign bus.o_WA_overflow     = ovf_q;
  assign bus.o_WA_state        = state_q;

endmodule

// File: tb/tb_word_assembler.sv
// tb/tb_word_assembler.sv - self-checking bench for word_assembler: vector table, corner
// sequences and randomized traffic against a word-level reference model.
module tb_word_assembler;

  localparam int STABLE = 4;
  localparam int P_COL = 0, P_START = 1, P_WAIT = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  word_assembler_if bus();

  word_assembler #(.STABLE_CNT(STABLE)) dut (
    .i_WA_clk   (clk),
    .i_WA_rst_n (rst_n),
    .bus        (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a byte array word, integer length and a run-length view of the input.
  logic [7:0]   m_word [15];
  int           m_len;
  logic [7:0]   m_last;
  logic         m_ovf;
  logic [119:0] m_result;
  int           m_phase;
  logic [7:0]   run_c;
  int           run_n;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 15; i++) m_word[i] = 8'h00;
    m_len = 0; m_last = 8'h00; m_ovf = 1'b0; m_result = '0;
    m_phase = P_COL; run_c = 8'h00; run_n = 0;
  endfunction

  function automatic void model_wipe();
    for (int i = 0; i < 15; i++) m_word[i] = 8'h00;
    m_len = 0; m_last = 8'h00; m_ovf = 1'b0;
  endfunction

  function automatic void apply_char(input logic [7:0] c);
    if (c == 8'h08) begin
      if (m_len > 0) begin
        m_len = m_len - 1;
        m_word[m_len] = 8'h00;
        m_last = 8'h00;
      end
    end else if (c == 8'h00) begin
      m_last = 8'h00;
    end else if (c != m_last) begin
      m_last = c;
      if (m_len == 15) m_ovf = 1'b1;
      else begin
        m_word[m_len] = c;
        m_len = m_len + 1;
      end
    end
  endfunction

  function automatic bit run_update(input logic v, input logic [7:0] c);
    if (!v) return 1'b0;
    if (c == run_c) run_n++;
    else begin
      run_c = c;
      run_n = 1;
    end
    return run_n == STABLE;
  endfunction

  function automatic void model_step(input logic v, input logic [7:0] c, input logic cm,
                                     input logic cl, input logic fin, input logic [119:0] dw);
    bit acc;
    case (m_phase)
      P_COL: begin
        if (cl) begin
          run_c = 8'h00; run_n = 0;
          model_wipe();
        end else begin
          acc = run_update(v, c);
          if (cm && m_len > 0) m_phase = P_START;
          else if (acc) apply_char(c);
        end
      end
      P_START: begin
        run_c = 8'h00; run_n = 0;
        m_phase = P_WAIT;
      end
      P_WAIT: begin
        run_c = 8'h00; run_n = 0;
        if (fin) begin
          m_result = dw;
          m_phase = P_DONE;
        end
      end
      default: begin
        acc = run_update(v, c);
        model_wipe();
        m_phase = P_COL;
      end
    endcase
  endfunction

  function automatic logic [2:0] exp_state();
    case (m_phase)
      P_COL:   return (m_len > 0) ? 3'd1 : 3'd0;
      P_START: return 3'd2;
      P_WAIT:  return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  task automatic compare_model();
    logic [119:0] ew;
    ew = '0;
    for (int i = 0; i < 15; i++) ew[i*8 +: 8] = m_word[i];
    check("model",
          {bus.o_WA_word, bus.o_WA_len, bus.o_WA_start, bus.o_WA_result,
           bus.o_WA_result_valid, bus.o_WA_overflow, bus.o_WA_state},
          {ew, 4'(m_len), (m_phase == P_START), m_result, (m_phase == P_DONE), m_ovf, exp_state()});
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic cm, input logic cl,
                      input logic fin, input logic [119:0] dw);
    bus.i_WA_char_valid = v;
    bus.i_WA_char       = c;
    bus.i_WA_commit     = cm;
    bus.i_WA_clear      = cl;
    bus.i_WA_dtw_finish = fin;
    bus.i_WA_dtw_word   = dw;
    model_step(v, c, cm, cl, fin, dw);
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic feed(input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) step(1'b1, c, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  c;
    logic        cm;
    logic        cl;
    logic [3:0]  len;
    logic [2:0]  st;
    logic        start;
    logic [15:0] w16;
  } vec_t;

  vec_t         tbl [11];
  logic [7:0]   pool [6];
  logic [127:0] rnd;
  logic [7:0]   cur;
  int           hold;
  int           cyc;

  initial begin
    tbl[0]  = '{1'b1, 8'h48, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 8'h48, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 8'h48, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 8'h48, 1'b0, 1'b0, 4'd1, 3'd1, 1'b0, 16'h0048};
    tbl[4]  = '{1'b1, 8'h49, 1'b0, 1'b0, 4'd1, 3'd1, 1'b0, 16'h0048};
    tbl[5]  = '{1'b1, 8'h49, 1'b0, 1'b0, 4'd1, 3'd1, 1'b0, 16'h0048};
    tbl[6]  = '{1'b1, 8'h49, 1'b0, 1'b0, 4'd1, 3'd1, 1'b0, 16'h0048};
    tbl[7]  = '{1'b1, 8'h49, 1'b0, 1'b0, 4'd2, 3'd1, 1'b0, 16'h4948};
    tbl[8]  = '{1'b0, 8'h48, 1'b0, 1'b0, 4'd2, 3'd1, 1'b0, 16'h4948};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 4'd0, 3'd0, 1'b0, 16'h0000};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 16'h0000};
    pool[0] = 8'h41; pool[1] = 8'h42; pool[2] = 8'h43;
    pool[3] = 8'h00; pool[4] = 8'h08; pool[5] = 8'h5A;

    bus.i_WA_char_valid = 1'b0; bus.i_WA_char = 8'h00; bus.i_WA_commit = 1'b0;
    bus.i_WA_clear = 1'b0; bus.i_WA_dtw_finish = 1'b0; bus.i_WA_dtw_word = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {bus.o_WA_word, bus.o_WA_len, bus.o_WA_start, bus.o_WA_result,
           bus.o_WA_result_valid, bus.o_WA_overflow, bus.o_WA_state}, '0);
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(tbl[i].v, tbl[i].c, tbl[i].cm, tbl[i].cl, 1'b0, '0);
      check($sformatf("vec%0d", i),
            {bus.o_WA_len, bus.o_WA_state, bus.o_WA_start, bus.o_WA_word[15:0]},
            {tbl[i].len, tbl[i].st, tbl[i].start, tbl[i].w16});
    end

    // Doubled letter needs an intervening rest.
    feed(8'h4C, 4); feed(8'h4C, 8);
    check("dup_len", bus.o_WA_len, 4'd1);
    feed(8'h00, 4); feed(8'h4C, 4);
    check("double_len", bus.o_WA_len, 4'd2);
    check("double_slot1", bus.o_WA_word[15:8], 8'h4C);

    // Fill to capacity, overflow, then backspace.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 15; i++) feed(8'h41 + 8'(i), 4);
    check("full_len", bus.o_WA_len, 4'd15);
    check("full_no_ovf", bus.o_WA_overflow, 1'b0);
    feed(8'h50, 4);
    check("ovf_len", bus.o_WA_len, 4'd15);
    check("ovf_flag", bus.o_WA_overflow, 1'b1);
    feed(8'h08, 4);
    check("bksp_len", bus.o_WA_len, 4'd14);
    check("bksp_slot14", bus.o_WA_word[119:112], 8'h00);
    check("bksp_slot13", bus.o_WA_word[111:104], 8'h4E);
    check("bksp_ovf_sticky", bus.o_WA_overflow, 1'b1);

    // Commit, matcher handshake, result pulse.
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, '0);
    feed(8'h43, 4); feed(8'h41, 4); feed(8'h54, 4);
    check("cat_len", bus.o_WA_len, 4'd3);
    step(1'b1, 8'h58, 1'b1, 1'b0, 1'b0, '0);
    check("start_pulse", {bus.o_WA_start, bus.o_WA_state}, {1'b1, 3'd2});
    step(1'b1, 8'h58, 1'b1, 1'b1, 1'b0, '0);
    check("start_gone", {bus.o_WA_start, bus.o_WA_state}, {1'b0, 3'd3});
    for (int i = 0; i < 6; i++) step(1'b1, 8'h58, 1'b0, 1'b1, 1'b0, '0);
    check("wait_frozen", {bus.o_WA_state, bus.o_WA_len, bus.o_WA_word[23:0]}, {3'd3, 4'd3, 24'h544143});
    step(1'b1, 8'h58, 1'b0, 1'b0, 1'b1, 120'h544143);
    check("result_valid", {bus.o_WA_result_valid, bus.o_WA_state}, {1'b1, 3'd4});
    check("result_word", bus.o_WA_result, 120'h544143);
    idle();
    check("done_exit", {bus.o_WA_result_valid, bus.o_WA_state, bus.o_WA_len, bus.o_WA_word},
          {1'b0, 3'd0, 4'd0, 120'h0});
    check("result_held", bus.o_WA_result, 120'h544143);

    // Asynchronous reset while the matcher is busy; its late finish must be dropped.
    feed(8'h41, 4);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
    idle();
    check("in_wait", bus.o_WA_state, 3'd3);
    rst_n = 1'b0;
    #2;
    check("async_reset",
          {bus.o_WA_word, bus.o_WA_len, bus.o_WA_start, bus.o_WA_result,
           bus.o_WA_result_valid, bus.o_WA_overflow, bus.o_WA_state}, '0);
    model_reset();
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 120'h1234);
    check("late_finish", {bus.o_WA_result_valid, bus.o_WA_state}, {1'b0, 3'd0});
    idle();
    check("late_finish_result", {bus.o_WA_result_valid, bus.o_WA_result}, '0);

    // Randomized traffic against the model.
    cyc = 0;
    while (cyc < 3000) begin
      cur  = pool[$urandom_range(0, 5)];
      hold = $urandom_range(1, 8);
      for (int h = 0; h < hold; h++) begin
        rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
        step($urandom_range(0, 9) != 0, cur, $urandom_range(0, 29) == 0,
             $urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, rnd[119:0]);
        cyc++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/word_assembler.md
WORD_ASSEMBLER -- requirements
Module: word_assembler

Interface
REQ-001 SHALL have parameter STABLE_CNT, default 4, meaning consecutive identical valid samples needed to accept a character (legal 1..15).
REQ-002 SHALL have i_WA_clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have i_WA_rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have i_WA_char_valid  input  1  the i_WA_char sample is valid this cycle.
REQ-005 SHALL have i_WA_char  input  8  classifier output: ASCII letter, 8'h00 = rest, 8'h08 = backspace.
REQ-006 SHALL have i_WA_commit  input  1  end-of-word gesture, level sampled each cycle.
REQ-007 SHALL have i_WA_clear  input  1  discard current word.
REQ-008 SHALL have i_WA_dtw_finish  input  1  one-cycle done pulse from the DTW matcher.
REQ-009 SHALL have i_WA_dtw_word  input  120  best candidate returned by the matcher.
REQ-010 SHALL have o_WA_word  output  120  assembled word; char k at bits [8k+7:8k], unused slots 8'h00.
REQ-011 SHALL have o_WA_len  output  4  number of characters held (0..15).
REQ-012 SHALL have o_WA_start  output  1  one-cycle start pulse to the matcher.
REQ-013 SHALL have o_WA_result  output  120  latched matcher result.
REQ-014 SHALL have o_WA_result_valid  output  1  one-cycle pulse, o_WA_result updated.
REQ-015 SHALL have o_WA_overflow  output  1  sticky: a letter was dropped because the word was full.
REQ-016 SHALL have o_WA_state  output  3  current state encoding, for debug.

Function
REQ-017 SHALL implement states S_IDLE=0, S_COLLECT=1, S_START=2, S_WAIT=3, S_DONE=4.
REQ-018 Debounce: valid sample equal to held candidate increments a saturating 4-bit counter; a differing sample loads the candidate and sets the counter to 1; a cycle with i_WA_char_valid=0 holds both.
REQ-019 Exactly one accept event SHALL fire, in the cycle the counter reaches STABLE_CNT; no further accept until the candidate changes.
REQ-020 Accepted letter (not 00/08) SHALL be written to slot o_WA_len and increment o_WA_len, visible the next cycle, unless it equals the last accepted letter.
REQ-021 Accepted rest (00) SHALL clear the last-letter register, so a doubled letter needs letter-rest-letter.
REQ-022 Accepted backspace with len>0 SHALL zero slot len-1, decrement len and clear the last-letter register; with len=0 it is a no-op.
REQ-023 Accepting a letter with len=15 SHALL drop it and set o_WA_overflow.
REQ-024 S_IDLE goes to S_COLLECT on the first appended letter; S_COLLECT returns to S_IDLE when len reaches 0 via backspace.
REQ-025 i_WA_commit in S_COLLECT with len>=1 SHALL go to S_START; a commit with len=0 SHALL be ignored.
REQ-026 S_START SHALL assert o_WA_start for exactly one cycle, then go to S_WAIT.
REQ-027 In S_START and S_WAIT, o_WA_word and o_WA_len SHALL stay frozen, and char, commit and clear inputs SHALL be ignored, with the debounce counter held at 0.
REQ-028 In S_WAIT, i_WA_dtw_finish SHALL latch i_WA_dtw_word into o_WA_result and go to S_DONE.
REQ-029 S_DONE SHALL pulse o_WA_result_valid for one cycle, and SHALL zero word, len, last-letter and overflow before going to S_IDLE.
REQ-030 Priority within a cycle: clear > commit > accept; an accept coinciding with commit or clear SHALL be discarded.
REQ-031 i_WA_clear in S_IDLE or S_COLLECT SHALL zero word, len, last-letter, overflow and the debounce state, and go to S_IDLE.

Reset
REQ-032 Asserting i_WA_rst_n low SHALL immediately force S_IDLE and zero all outputs, the candidate, the counter and the last-letter register, including mid-S_WAIT.
REQ-033 A matcher finish pulse arriving after reset SHALL be ignored, because the state is not S_WAIT.

Structure
REQ-034 The shared package SHALL hold MAX_CHARS=15, CHAR_W=8, CHAR_REST=8'h00, CHAR_BKSP=8'h08 and the state enum.
REQ-035 Debounce SHALL be a sub-module char_debouncer, outputting accept pulse plus accepted char.

Verification
REQ-036 STABLE_CNT=4: feed 'H' x4 valid cycles, then 'I' x4 -> o_WA_word[15:0]=16'h4948, len=2.
REQ-037 Feed 'L' x4, 'L' x8 -> len=1; then 00 x4, 'L' x4 -> len=2, slot1=8'h4C.
REQ-038 Build 15 letters, then one more -> len=15, overflow=1; backspace x4 -> len=14, slot14=00.
REQ-039 len=3, then commit -> o_WA_start high one cycle; inputs ignored; finish with word "CAT" -> o_WA_result="CAT", result_valid one cycle, len=0.
REQ-040 Commit and clear in the same cycle -> S_IDLE, no o_WA_start; rst_n low during S_WAIT -> all outputs 0, later finish produces no result_valid.
